// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts CUT responses into a MISR and checks the
// final signature and word count against golden values.
module bist_response_analyzer #(
    parameter int                 WIDTH         = 10,
    parameter logic [WIDTH-1:0]   POLY          = 10'h009,
    parameter logic [WIDTH-1:0]   GOLDEN        = 10'h000,
    parameter int                 PATTERN_COUNT = 1022,
    parameter int                 CNT_W         = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             complete_in,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sig, sig_next, misr_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic             pass_q, pass_next;
    logic             fail_q, fail_next;
    logic             match;

    // Shift left, fold the outgoing MSB back through the polynomial, absorb the word.
    assign misr_next = ({sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0)) ^ data_in;
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
    assign match     = (sig == GOLDEN) && (cnt == CNT_W'(PATTERN_COUNT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            sig    <= '0;
            cnt    <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            state  <= state_next;
            sig    <= sig_next;
            cnt    <= cnt_next;
            pass_q <= pass_next;
            fail_q <= fail_next;
        end
    end

    always_comb begin
        state_next = state;
        sig_next   = sig;
        cnt_next   = cnt;
        pass_next  = pass_q;
        fail_next  = fail_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COMPACT;
                    sig_next   = '0;
                    cnt_next   = '0;
                end
            end
            COMPACT: begin
                // The word arriving alongside complete_in is still the last one to count.
                if (data_valid) begin
                    sig_next = misr_next;
                    cnt_next = cnt_inc;
                end
                if (complete_in) state_next = COMPARE;
            end
            COMPARE: begin
                pass_next  = match;
                fail_next  = !match;
                state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    state_next = COMPACT;
                    sig_next   = '0;
                    cnt_next   = '0;
                    pass_next  = 1'b0;
                    fail_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign signature  = sig;
    assign word_count = cnt;
    assign busy       = (state == COMPACT) || (state == COMPARE);
    assign done       = (state == DONE);
    assign pass       = pass_q;
    assign fail       = fail_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed bench for bist_response_analyzer: vector table plus hand-written
// sequences for feedback/pass, count mismatch, full generator run, reset abort.
module tb_bist_response_analyzer;

    localparam int W  = 10;
    localparam int CW = 11;
    localparam int FULL_N = 1022;

    function automatic logic [W-1:0] misr_step(logic [W-1:0] s, logic [W-1:0] d);
        return ({s[W-2:0], 1'b0} ^ (s[W-1] ? 10'h009 : 10'h000)) ^ d;
    endfunction

    // Generator stand-in: maximal-length x^10+x^7+1 LFSR seeded with 1.
    function automatic logic [W-1:0] lfsr_step(logic [W-1:0] v);
        return {v[W-2:0], v[9] ^ v[6]};
    endfunction

    function automatic logic [W-1:0] calc_golden(int n);
        logic [W-1:0] s;
        logic [W-1:0] w;
        s = '0;
        w = 10'h001;
        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++)
                if (a * 32 + b < n) begin
                    s = misr_step(s, w);
                    w = lfsr_step(w);
                end
        return s;
    endfunction

    localparam logic [W-1:0] FULL_GOLDEN = calc_golden(FULL_N);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          data_valid = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          complete_in = 1'b0;

    logic [W-1:0]  sig_d, sig_p, sig_c, sig_f;
    logic [CW-1:0] cnt_d, cnt_p, cnt_c, cnt_f;
    logic          busy_d, done_d, pass_d, fail_d;
    logic          busy_p, done_p, pass_p, fail_p;
    logic          busy_c, done_c, pass_c, fail_c;
    logic          busy_f, done_f, pass_f, fail_f;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    bist_response_analyzer dut (
        .clock(clock), .reset(reset), .start(start), .data_valid(data_valid),
        .data_in(data_in), .complete_in(complete_in), .signature(sig_d),
        .word_count(cnt_d), .busy(busy_d), .done(done_d), .pass(pass_d), .fail(fail_d));

    bist_response_analyzer #(.GOLDEN(10'h009), .PATTERN_COUNT(2)) dut_p (
        .clock(clock), .reset(reset), .start(start), .data_valid(data_valid),
        .data_in(data_in), .complete_in(complete_in), .signature(sig_p),
        .word_count(cnt_p), .busy(busy_p), .done(done_p), .pass(pass_p), .fail(fail_p));

    bist_response_analyzer #(.GOLDEN(10'h009), .PATTERN_COUNT(3)) dut_c (
        .clock(clock), .reset(reset), .start(start), .data_valid(data_valid),
        .data_in(data_in), .complete_in(complete_in), .signature(sig_c),
        .word_count(cnt_c), .busy(busy_c), .done(done_c), .pass(pass_c), .fail(fail_c));

    bist_response_analyzer #(.GOLDEN(FULL_GOLDEN), .PATTERN_COUNT(FULL_N)) dut_f (
        .clock(clock), .reset(reset), .start(start), .data_valid(data_valid),
        .data_in(data_in), .complete_in(complete_in), .signature(sig_f),
        .word_count(cnt_f), .busy(busy_f), .done(done_f), .pass(pass_f), .fail(fail_f));

    typedef struct {
        logic          start;
        logic          dv;
        logic [W-1:0]  din;
        logic          cmp;
        logic [W-1:0]  sig;
        logic [CW-1:0] cnt;
        logic          busy;
        logic          done;
        logic          pass;
        logic          fail;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic dv, input logic [W-1:0] d, input logic c);
        start       = s;
        data_valid  = dv;
        data_in     = d;
        complete_in = c;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] s, input logic [CW-1:0] c,
                             input logic b, input logic dn, input logic p, input logic f);
        check({tag, " sig"},  32'(sig_d),  32'(s));
        check({tag, " cnt"},  32'(cnt_d),  32'(c));
        check({tag, " busy"}, 32'(busy_d), 32'(b));
        check({tag, " done"}, 32'(done_d), 32'(dn));
        check({tag, " pass"}, 32'(pass_d), 32'(p));
        check({tag, " fail"}, 32'(fail_d), 32'(f));
    endtask

    initial begin
        logic [W-1:0] model_sig;
        logic [W-1:0] word;

        //            start dv  din     cmp  sig     cnt busy done pass fail
        vecs[0]  = '{1'b0, 1'b1, 10'h3ff, 1'b0, 10'h000, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 10'h001, 1'b0, 10'h001, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 10'h000, 1'b1, 10'h002, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h002, 2, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 10'h3ff, 1'b1, 10'h002, 2, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 10'h200, 1'b0, 10'h200, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 10'h000, 1'b0, 10'h009, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 10'h001, 1'b0, 10'h013, 3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 10'h000, 1'b1, 10'h013, 3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h013, 3, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state, checked while reset is still held.
        #12;
        check_out("reset", 10'h000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check_out("idle", 10'h000, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].dv, vecs[i].din, vecs[i].cmp);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].sig, vecs[i].cnt, vecs[i].busy,
                      vecs[i].done, vecs[i].pass, vecs[i].fail);
        end

        // Feedback path: pass on exact match, fail on count mismatch.
        drive(1'b1, 1'b0, 10'h000, 1'b0); tick();
        drive(1'b0, 1'b1, 10'h200, 1'b0); tick();
        drive(1'b0, 1'b1, 10'h000, 1'b1); tick();
        check("fb compare busy", 32'(busy_p), 32'd1);
        check("fb compare done", 32'(done_p), 32'd0);
        drive(1'b0, 1'b0, 10'h000, 1'b0); tick();
        check("fb sig",        32'(sig_p),  32'h009);
        check("fb cnt",        32'(cnt_p),  32'd2);
        check("fb done",       32'(done_p), 32'd1);
        check("fb pass",       32'(pass_p), 32'd1);
        check("fb fail",       32'(fail_p), 32'd0);
        check("cntmis done",   32'(done_c), 32'd1);
        check("cntmis pass",   32'(pass_c), 32'd0);
        check("cntmis fail",   32'(fail_c), 32'd1);
        check("gold0 fail",    32'(fail_d), 32'd1);
        repeat (3) tick();
        check("fb hold pass",  32'(pass_p), 32'd1);
        check("fb hold sig",   32'(sig_p),  32'h009);

        // Full run against the generator model, complete_in on the last word.
        drive(1'b1, 1'b0, 10'h000, 1'b0); tick();
        model_sig = '0;
        word = 10'h001;
        for (int i = 0; i < FULL_N; i++) begin
            drive(1'b0, 1'b1, word, (i == FULL_N - 1));
            tick();
            model_sig = misr_step(model_sig, word);
            word = lfsr_step(word);
        end
        drive(1'b0, 1'b0, 10'h000, 1'b0); tick();
        check("full sig",  32'(sig_f),  32'(model_sig));
        check("full cnt",  32'(cnt_f),  FULL_N);
        check("full done", 32'(done_f), 32'd1);
        check("full pass", 32'(pass_f), 32'd1);
        check("full fail", 32'(fail_f), 32'd0);

        // Counter saturation at all-ones.
        drive(1'b1, 1'b0, 10'h000, 1'b0); tick();
        for (int i = 0; i < 2050; i++) begin
            drive(1'b0, 1'b1, 10'(i), 1'b0);
            tick();
        end
        check("sat cnt", 32'(cnt_d), 32'h7ff);

        // Reset mid-COMPACT clears everything without waiting for an edge.
        drive(1'b0, 1'b1, 10'h155, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_out("abort", 10'h000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b1, 10'h0aa, 1'b1);
        tick();
        check("abort idle sig",  32'(sig_d),  32'h000);
        check("abort idle busy", 32'(busy_d), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
